// File: rtl/seq_alu.sv
// Sequential single-request ALU: accept in IDLE, compute in EXEC, present in HOLD
// until the consumer takes the result.
module seq_alu #(
    parameter int unsigned M = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [1:0]   i_op,
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status,
    output logic         o_err
);

    if (M < 4) begin : g_width_check
        $error("seq_alu: M must be at least 4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StHold
    } state_e;

    localparam logic [1:0] OpSub    = 2'b00;
    localparam logic [1:0] OpLt     = 2'b01;
    localparam logic [1:0] OpSetbit = 2'b10;
    localparam logic [1:0] OpSm2tc  = 2'b11;

    state_e         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [M-1:0]   arga_q, arga_d;
    logic [M-1:0]   argb_q, argb_d;
    logic [M-1:0]   result_q, result_d;
    logic [3:0]     status_q, status_d;
    logic           err_q, err_d;

    logic [M-1:0]   calc_res;
    logic           calc_err;
    logic [M-1:0]   diff;
    logic [M-1:0]   mag_ext;

    always_comb begin
        calc_res = '0;
        calc_err = 1'b0;
        diff     = arga_q - argb_q;
        mag_ext  = {1'b0, arga_q[M-2:0]};
        unique case (op_q)
            OpSub: begin
                calc_res = diff;
                calc_err = (arga_q[M-1] ^ argb_q[M-1]) & (diff[M-1] ^ arga_q[M-1]);
            end
            OpLt: begin
                calc_res = {{(M-1){1'b0}}, (arga_q < argb_q)};
            end
            OpSetbit: begin
                // Bit index is compared at full operand width so large B flags an error.
                if (argb_q < M'(M)) begin
                    calc_res = arga_q | (M'(1) << argb_q);
                end else begin
                    calc_res = arga_q;
                    calc_err = 1'b1;
                end
            end
            OpSm2tc: begin
                // Negative zero falls out naturally: -(0) == 0.
                calc_res = arga_q[M-1] ? (~mag_ext + M'(1)) : arga_q;
            end
            default: begin
                calc_res = '0;
                calc_err = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        arga_d   = arga_q;
        argb_d   = argb_q;
        result_d = result_q;
        status_d = status_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    op_d    = i_op;
                    arga_d  = i_argA;
                    argb_d  = i_argB;
                    state_d = StExec;
                end
            end
            StExec: begin
                result_d    = calc_res;
                status_d[0] = (calc_res == '0);
                status_d[1] = calc_res[M-1];
                status_d[2] = ~^calc_res;
                status_d[3] = &calc_res;
                err_d       = calc_err;
                state_d     = StHold;
            end
            StHold: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            arga_q   <= '0;
            argb_q   <= '0;
            result_q <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            arga_q   <= arga_d;
            argb_q   <= argb_d;
            result_q <= result_d;
            status_q <= status_d;
            err_q    <= err_d;
        end
    end

    assign o_ready  = (state_q == StIdle);
    assign o_valid  = (state_q == StHold);
    assign o_result = result_q;
    assign o_status = status_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (M=8) with hand-computed expected values.
module tb_seq_alu;

    localparam int unsigned M = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [1:0]   op;
    logic [M-1:0] arg_a;
    logic [M-1:0] arg_b;
    logic         out_valid;
    logic         in_ready;
    logic [M-1:0] result;
    logic [3:0]   status;
    logic         err;

    int checks = 0;
    int errors = 0;

    seq_alu #(.M(M)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_op     (op),
        .i_argA   (arg_a),
        .i_argB   (arg_b),
        .o_valid  (out_valid),
        .i_ready  (in_ready),
        .o_result (result),
        .o_status (status),
        .o_err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] res, input logic [3:0] st,
                             input logic e);
        check({tag, " result"}, 32'(result), 32'(res));
        check({tag, " status"}, 32'(status), 32'(st));
        check({tag, " err"}, 32'(err), 32'(e));
    endtask

    // Issue one request and stop in HOLD (i_ready held low).
    task automatic issue(input string tag, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b);
        @(negedge clk);
        check({tag, " ready before accept"}, 32'(out_ready), 32'd1);
        in_valid = 1'b1;
        op       = o;
        arg_a    = a;
        arg_b    = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, " valid low in exec"}, 32'(out_valid), 32'd0);
        check({tag, " ready low in exec"}, 32'(out_ready), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " valid in hold"}, 32'(out_valid), 32'd1);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        check({tag, " ready after consume"}, 32'(out_ready), 32'd1);
        check({tag, " valid after consume"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        op       = 2'b00;
        arg_a    = '0;
        arg_b    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset valid", 32'(out_valid), 32'd0);
        check("reset ready", 32'(out_ready), 32'd1);
        check_out("reset", 8'h00, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("sub 05-07", 2'b00, 8'h05, 8'h07);
        check_out("sub 05-07", 8'hFE, 4'b0010, 1'b0);
        consume("sub 05-07");

        issue("sub 7f-ff", 2'b00, 8'h7F, 8'hFF);
        check_out("sub 7f-ff", 8'h80, 4'b0010, 1'b1);
        consume("sub 7f-ff");

        issue("sub ff-00", 2'b00, 8'hFF, 8'h00);
        check_out("sub ff-00", 8'hFF, 4'b1110, 1'b0);
        consume("sub ff-00");

        issue("sub 80-01", 2'b00, 8'h80, 8'h01);
        check_out("sub 80-01", 8'h7F, 4'b0000, 1'b1);
        consume("sub 80-01");

        // Reset while a request sits in EXEC.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'b00;
        arg_a    = 8'h05;
        arg_b    = 8'h07;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst exec ready low", 32'(out_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst async valid", 32'(out_valid), 32'd0);
        check("rst async ready", 32'(out_ready), 32'd1);
        check_out("rst async", 8'h00, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post-rst no valid", 32'(out_valid), 32'd0);
            check("post-rst ready", 32'(out_ready), 32'd1);
        end

        issue("setbit 00,08", 2'b10, 8'h00, 8'h08);
        check_out("setbit 00,08", 8'h00, 4'b0101, 1'b1);
        consume("setbit 00,08");

        issue("setbit 00,03", 2'b10, 8'h00, 8'h03);
        check_out("setbit 00,03", 8'h08, 4'b0000, 1'b0);
        consume("setbit 00,03");

        issue("setbit 01,07", 2'b10, 8'h01, 8'h07);
        check_out("setbit 01,07", 8'h81, 4'b0110, 1'b0);
        consume("setbit 01,07");

        issue("setbit 00,f0", 2'b10, 8'h00, 8'hF0);
        check_out("setbit 00,f0", 8'h00, 4'b0101, 1'b1);
        consume("setbit 00,f0");

        issue("sm2tc 85", 2'b11, 8'h85, 8'h00);
        check_out("sm2tc 85", 8'hFB, 4'b0010, 1'b0);
        consume("sm2tc 85");

        issue("sm2tc 80", 2'b11, 8'h80, 8'h33);
        check_out("sm2tc 80", 8'h00, 4'b0101, 1'b0);
        consume("sm2tc 80");

        issue("sm2tc 05", 2'b11, 8'h05, 8'hFF);
        check_out("sm2tc 05", 8'h05, 4'b0100, 1'b0);
        consume("sm2tc 05");

        issue("sm2tc ff", 2'b11, 8'hFF, 8'h00);
        check_out("sm2tc ff", 8'h81, 4'b0110, 1'b0);
        consume("sm2tc ff");

        issue("lt 03<c8", 2'b01, 8'h03, 8'hC8);
        check_out("lt 03<c8", 8'h01, 4'b0000, 1'b0);
        consume("lt 03<c8");

        issue("lt 10<10", 2'b01, 8'h10, 8'h10);
        check_out("lt 10<10", 8'h00, 4'b0101, 1'b0);
        consume("lt 10<10");

        issue("lt c8<03", 2'b01, 8'hC8, 8'h03);
        check_out("lt c8<03", 8'h00, 4'b0101, 1'b0);
        consume("lt c8<03");

        // Backpressure: HOLD with new requests offered must not disturb the result.
        issue("bp sub", 2'b00, 8'h05, 8'h07);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op       = 2'(i);
            arg_a    = 8'(8'h11 * (i + 1));
            arg_b    = 8'(8'h23 + i);
            @(posedge clk);
            #1;
            check_out("bp hold", 8'hFE, 4'b0010, 1'b0);
            check("bp valid", 32'(out_valid), 32'd1);
            check("bp ready", 32'(out_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume("bp release");
        @(posedge clk);
        #1;
        check("bp no queued accept", 32'(out_ready), 32'd1);
        check("bp no queued valid", 32'(out_valid), 32'd0);
        check_out("bp retained", 8'hFE, 4'b0010, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
